// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential comparator: state codes, result flags,
// and the chunk-count / counter-width derivations.
package cmp_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic eq;
    logic sg;
    logic ug;
    logic mg;
    logic xg;
  } cmp_flags_t;

  function automatic int calc_n(input int len, input int chunk);
    return len / chunk;
  endfunction

  function automatic int calc_cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one W-bit chunk.
module cmp_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         chunk_eq,
  output logic         chunk_gt
);
  assign chunk_eq = (a_i == b_i);
  assign chunk_gt = (a_i > b_i);
endmodule

// File: rtl/cmp_seq.sv
// Handshaked multi-cycle comparator: walks the operands MSB chunk first and
// returns EQ/SG/UG/MG/XG after a fixed N-cycle run.
module cmp_seq
  import cmp_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           EQ,
  output logic           SG,
  output logic           UG,
  output logic           MG,
  output logic           XG
);
  localparam int N  = calc_n(LEN, CHUNK);
  localparam int CW = calc_cw(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]     state_q, state_d;
  logic [LEN-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           eq_acc_q, eq_acc_d, gt_acc_q, gt_acc_d;
  cmp_flags_t     flags_q, flags_d;

  logic [LEN-1:0]   a_sh, b_sh;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic             chunk_eq, chunk_gt;
  logic             xfer;

  // Chunk index N-1-cnt: the MSB chunk is visited first.
  assign a_sh = a_q >> (CHUNK * (N - 1 - int'(cnt_q)));
  assign b_sh = b_q >> (CHUNK * (N - 1 - int'(cnt_q)));
  assign a_ch = a_sh[CHUNK-1:0];
  assign b_ch = b_sh[CHUNK-1:0];

  cmp_chunk #(.W(CHUNK)) u_chunk (
    .a_i      (a_ch),
    .b_i      (b_ch),
    .chunk_eq (chunk_eq),
    .chunk_gt (chunk_gt)
  );

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign xfer      = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    flags_d  = flags_q;
    case (state_q)
      S_RUN: begin
        // Once a chunk differs the accumulators freeze: that chunk decides.
        if (eq_acc_q) begin
          eq_acc_d = chunk_eq;
          gt_acc_d = chunk_gt;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d    = S_DONE;
          flags_d.eq = eq_acc_d;
          flags_d.ug = gt_acc_d;
          flags_d.sg = (a_q[LEN-1] != b_q[LEN-1]) ? b_q[LEN-1] : gt_acc_d;
          flags_d.mg = gt_acc_d;
          flags_d.xg = gt_acc_d;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (xfer) begin
      a_d      = A;
      b_d      = B;
      cnt_d    = '0;
      eq_acc_d = 1'b1;
      gt_acc_d = 1'b0;
      state_d  = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      flags_q  <= flags_d;
    end
  end

  assign EQ = flags_q.eq;
  assign SG = flags_q.sg;
  assign UG = flags_q.ug;
  assign MG = flags_q.mg;
  assign XG = flags_q.xg;
endmodule

// File: tb/tb_cmp_seq.sv
// Directed-vector bench for cmp_seq at CHUNK=1, 4 and 16 (LEN=16).
module tb_cmp_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv = '0, ir, ov, ordy = '0;
  logic [2:0]  eq, sg, ug, mg, xg;
  logic [15:0] a_s [3];
  logic [15:0] b_s [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int CH = (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    cmp_seq #(.LEN(16), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[k]),
      .in_ready  (ir[k]),
      .A         (a_s[k]),
      .B         (b_s[k]),
      .out_valid (ov[k]),
      .out_ready (ordy[k]),
      .EQ        (eq[k]),
      .SG        (sg[k]),
      .UG        (ug[k]),
      .MG        (mg[k]),
      .XG        (xg[k])
    );
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  f;   // {EQ,SG,UG,MG,XG}
  } vec_t;
  vec_t tbl [8];

  function automatic int nof(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic [4:0] flg(input int k);
    return {eq[k], sg[k], ug[k], mg[k], xg[k]};
  endfunction

  function automatic logic [4:0] ref_flags(input logic [15:0] a, input logic [15:0] b);
    logic u;
    u = a > b;
    return {a == b, $signed(a) > $signed(b), u, u, u};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a transfer edge; counts cycles until out_valid.
  task automatic wait_res(input int k, output logic [4:0] f, output int lat);
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    f = flg(k);
  endtask

  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b,
                       output logic [4:0] f, output int lat);
    a_s[k] = a;
    b_s[k] = b;
    iv[k]  = 1'b1;
    @(posedge clk); #1;
    iv[k]  = 1'b0;
    wait_res(k, f, lat);
  endtask

  task automatic ack(input int k);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
  endtask

  initial begin
    logic [4:0]  f;
    logic [15:0] ra, rb;
    int          lat, cnt;

    tbl[0] = '{16'h1234, 16'h1234, 5'b10000};
    tbl[1] = '{16'h8000, 16'h7FFF, 5'b00111};
    tbl[2] = '{16'h0001, 16'hFFFF, 5'b01000};
    tbl[3] = '{16'h2000, 16'h1FFF, 5'b01111};
    tbl[4] = '{16'h1235, 16'h1234, 5'b01111};
    tbl[5] = '{16'h0000, 16'h0001, 5'b00000};
    tbl[6] = '{16'hFFFF, 16'h0000, 5'b00111};
    tbl[7] = '{16'h7FFF, 16'h8000, 5'b01000};
    for (int k = 0; k < 3; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end

    // Reset state
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_flags[%0d]", k), 32'(flg(k)), 32'd0);
      chk($sformatf("rst_in_ready[%0d]", k), 32'(ir[k]), 32'd1);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table on every configuration
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        do_op(k, tbl[i].a, tbl[i].b, f, lat);
        chk($sformatf("tbl%0d_lat[%0d]", i, k), 32'(lat), 32'(nof(k)));
        chk($sformatf("tbl%0d_flags[%0d]", i, k), 32'(f), 32'(tbl[i].f));
        ack(k);
      end
    end

    // Random sweep against the reference comparison
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        ra = 16'($urandom);
        rb = (i % 5 == 0) ? ra : 16'($urandom);
        do_op(k, ra, rb, f, lat);
        chk($sformatf("rnd%0d_lat[%0d]", i, k), 32'(lat), 32'(nof(k)));
        chk($sformatf("rnd%0d_flags[%0d] a=%h b=%h", i, k, ra, rb), 32'(f), 32'(ref_flags(ra, rb)));
        ack(k);
      end
    end

    // Backpressure then simultaneous output/input transfer
    do_op(1, 16'h8000, 16'h7FFF, f, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", c), 32'(ov[1]), 32'd1);
      chk($sformatf("bp_in_ready_c%0d", c), 32'(ir[1]), 32'd0);
      chk($sformatf("bp_flags_c%0d", c), 32'(flg(1)), 32'h07);
    end
    ordy[1] = 1'b1;
    iv[1]   = 1'b1;
    a_s[1]  = 16'h0000;
    b_s[1]  = 16'h0001;
    #1;
    chk("b2b_in_ready", 32'(ir[1]), 32'd1);
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    iv[1]   = 1'b0;
    chk("b2b_out_dropped", 32'(ov[1]), 32'd0);
    chk("b2b_flags_held", 32'(flg(1)), 32'h07);
    wait_res(1, f, lat);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_flags", 32'(f), 32'h00);
    ack(1);

    // Reset in the second RUN cycle discards the operation
    do_op(1, 16'h8000, 16'h7FFF, f, lat);
    ack(1);
    chk("pre_rst_flags_held", 32'(flg(1)), 32'h07);
    a_s[1] = 16'hFFFF;
    b_s[1] = 16'h0000;
    iv[1]  = 1'b1;
    @(posedge clk); #1;
    iv[1]  = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(ov[1]), 32'd0);
    chk("midrst_flags", 32'(flg(1)), 32'd0);
    chk("midrst_in_ready", 32'(ir[1]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov[1]) cnt++;
    end
    chk("postrst_no_valid", 32'(cnt), 32'd0);
    chk("postrst_flags", 32'(flg(1)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cmp_seq.md
# cmp_seq

Multi-cycle, handshaked counterpart to the combinational comparator. Operands arrive through a valid/ready input port and are compared CHUNK bits per cycle, MSB chunk first. The same five flags (EQ, SG, UG, MG, XG) are returned on a valid/ready output port. It sits where operand width makes a single-cycle LEN-bit compare too deep, trading latency for a shallow per-cycle path.

## Interface
- LEN, 16: operand width; LEN must be a multiple of CHUNK.
- CHUNK, 4: bits compared per cycle; 1 ≤ CHUNK ≤ LEN.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- A  in  LEN  operand A, sampled on input transfer.
- B  in  LEN  operand B, sampled on input transfer.
- out_valid  out  1  result flags valid.
- out_ready  in  1  consumer takes result.
- EQ  out  1  A == B.
- SG  out  1  signed(A) > signed(B).
- UG  out  1  unsigned(A) > unsigned(B).
- MG  out  1  signed(A) > unsigned(B), with Verilog mixed-sign semantics.
- XG  out  1  unsigned(A) > signed(B), with Verilog mixed-sign semantics.

## Operation
- N = LEN/CHUNK chunks; cnt width = max(1, clog2(N)).
- States:
  - IDLE: in_ready=1.
  - RUN: iterate chunks.
  - DONE: out_valid=1.
- Input transfer occurs when in_valid && in_ready.
  - On transfer, register A and B, clear cnt, set eq_acc=1 and gt_acc=0, then go to RUN.
- in_ready = (state==IDLE) || (state==DONE && out_ready), so a new transfer can happen in the same cycle as the output transfer.
- RUN, per cycle on chunk index N-1-cnt:
  - If eq_acc is set: gt_acc = chunk_gt and eq_acc = chunk_eq.
  - Otherwise hold both; the first differing chunk decides the result.
  - cnt increments. After chunk 0 is processed, go to DONE.
- There is no early exit. Latency is fixed and independent of data.
- Flag computation at the RUN→DONE edge:
  - EQ = eq_acc.
  - UG = gt_acc.
  - SG = (A[LEN-1] != B[LEN-1]) ? B[LEN-1] : gt_acc.
  - MG = XG = UG. Mixing signed and unsigned operands makes the comparison unsigned, and this is a decided bit-exact match with the combinational block.
- DONE:
  - Hold out_valid and all flags until out_ready.
  - If out_ready and in_valid, go to RUN with the new operands.
  - If out_ready and not in_valid, go to IDLE.
- Flags are registered. They change only at RUN→DONE and hold between results.
- in_valid in RUN is ignored and not stored; the producer must hold it.
- Reset:
  - State IDLE, out_valid=0, all flags 0, cnt 0, operand registers 0.
  - in_ready reads 1 in reset, but no transfer is taken while rst_n is low.
  - Reset asserted mid-RUN or in DONE drops out_valid immediately (asynchronous) and discards the operation. No stale result appears after release.

## Timing
- Input transfer at edge T. RUN occupies edges T+1..T+N. out_valid=1 from just after edge T+N.
- Latency from input transfer to out_valid is N cycles.
- Throughput is one result per N+1 cycles with continuous in_valid and out_ready.
- CHUNK=LEN gives N=1: a single RUN cycle, latency 1.
- The critical path is one CHUNK-bit compare plus accumulator muxing, independent of LEN.

## Structure
- Package cmp_pkg holds:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - The N and count-width derivation functions.
- Sub-module cmp_chunk is a combinational CHUNK-bit unsigned compare with outputs chunk_eq and chunk_gt. It is instantiated once and fed by a chunk mux indexed by cnt.
- Top level holds the FSM, operand registers, accumulators and flag registers.

## Test plan
All scenarios use LEN=16, CHUNK=4 unless noted.
- Equal operands: A=0x1234, B=0x1234 → out_valid 4 cycles after transfer with EQ=1 and SG=UG=MG=XG=0.
- Sign boundary: A=0x8000, B=0x7FFF → EQ=0, UG=1, MG=1, XG=1, SG=0. Then A=0x0001, B=0xFFFF → UG=0, MG=0, XG=0, SG=1.
- Decisive chunk position:
  - A=0x2000, B=0x1FFF → UG=1; the first chunk decides and later chunks must not override.
  - A=0x1235, B=0x1234 → UG=1, SG=1, decided only by the last chunk.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid and flags stable, in_ready=0.
  - Then raise out_ready with in_valid=1 (A=0, B=1) in the same cycle → both transfers occur, and the next out_valid appears 4 cycles later with UG=0 and SG=0.
- Reset mid-operation: drop rst_n during the 2nd RUN cycle → out_valid=0 and flags 0 immediately, and no out_valid after release without a new input transfer.
- Sweep configs CHUNK=1, 4 and 16 with random operands against the combinational reference equations. Check latency N, and that EQ matches A==B and XG equals UG on every result.
